// File: rtl/conv_layer_mem_host_if.sv
// Bus between the convolution engine (master) and its memory/host responder (slave):
// start handshake, image read port and csel-banked layer memory read/write ports.
interface conv_layer_mem_host_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] idata;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic [2:0]        csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_layer_mem_host.sv
// Memory/host responder for the convolution engine: image and layer banks, start handshake,
// busy-cycle timer, sticky protocol-error flag, image loader and registered readback port.
module conv_layer_mem_host #(
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 12,
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int L2_DEPTH  = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 start,
  conv_layer_mem_host_if.slave eng,
  input  logic                 dump_req,
  input  logic [2:0]           dump_sel,
  input  logic [ADDR_W-1:0]    dump_addr,
  output logic                 dump_valid,
  output logic [DATA_W-1:0]    dump_data,
  output logic                 done,
  output logic                 err,
  output logic [23:0]          cycles
);
  localparam logic [2:0] SEL_IMG  = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;
  localparam int IMG_AW = $clog2(IMG_DEPTH);
  localparam int L0_AW  = $clog2(L0_DEPTH);
  localparam int L1_AW  = $clog2(L1_DEPTH);
  localparam int L2_AW  = $clog2(L2_DEPTH);
  localparam logic [23:0] CYC_MAX = 24'hFFFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [DATA_W-1:0] img_mem  [IMG_DEPTH];
  logic [DATA_W-1:0] l0k0_mem [L0_DEPTH];
  logic [DATA_W-1:0] l0k1_mem [L0_DEPTH];
  logic [DATA_W-1:0] l1k0_mem [L1_DEPTH];
  logic [DATA_W-1:0] l1k1_mem [L1_DEPTH];
  logic [DATA_W-1:0] l2_mem   [L2_DEPTH];

  state_t            state_r, state_s;
  logic              ready_r, done_r, err_r, dump_valid_r;
  logic [23:0]       cycles_r, cycles_s;
  logic [DATA_W-1:0] dump_data_r;
  logic              eng_wr_legal_s, eng_rd_legal_s, eng_wr_s, eng_rd_s, err_set_s;

  // Address is in range for the selected bank; unknown selects are never in range.
  function automatic logic addr_ok(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    logic ok_v;
    case (sel)
      SEL_IMG:            ok_v = (32'(addr) < 32'(IMG_DEPTH));
      SEL_L0K0, SEL_L0K1: ok_v = (32'(addr) < 32'(L0_DEPTH));
      SEL_L1K0, SEL_L1K1: ok_v = (32'(addr) < 32'(L1_DEPTH));
      SEL_L2:             ok_v = (32'(addr) < 32'(L2_DEPTH));
      default:            ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

  function automatic logic [DATA_W-1:0] read_bank(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] rd_v;
    rd_v = {DATA_W{1'b0}};
    if (addr_ok(sel, addr)) begin
      case (sel)
        SEL_IMG:  rd_v = img_mem[addr[IMG_AW-1:0]];
        SEL_L0K0: rd_v = l0k0_mem[addr[L0_AW-1:0]];
        SEL_L0K1: rd_v = l0k1_mem[addr[L0_AW-1:0]];
        SEL_L1K0: rd_v = l1k0_mem[addr[L1_AW-1:0]];
        SEL_L1K1: rd_v = l1k1_mem[addr[L1_AW-1:0]];
        SEL_L2:   rd_v = l2_mem[addr[L2_AW-1:0]];
        default:  rd_v = {DATA_W{1'b0}};
      endcase
    end else begin
      rd_v = {DATA_W{1'b0}};
    end
    return rd_v;
  endfunction

  // The image bank is reachable only through iaddr/loader/dump, never through csel.
  assign eng_wr_legal_s = (eng.csel != SEL_IMG) && addr_ok(eng.csel, eng.caddr_wr);
  assign eng_rd_legal_s = (eng.csel != SEL_IMG) && addr_ok(eng.csel, eng.caddr_rd);
  assign eng_wr_s       = eng.cwr && !eng.crd && eng_wr_legal_s;
  assign eng_rd_s       = eng.crd && !eng.cwr && eng_rd_legal_s;
  assign err_set_s      = (eng.cwr && !eng_wr_legal_s) || (eng.crd && !eng_rd_legal_s) ||
                          (eng.cwr && eng.crd) || (ld_valid && (state_r == S_RUN)) ||
                          (eng.busy && (state_r == S_IDLE));

  assign eng.idata    = img_mem[eng.iaddr[IMG_AW-1:0]];
  assign eng.cdata_rd = eng_rd_s ? read_bank(eng.csel, eng.caddr_rd) : {DATA_W{1'b0}};
  assign eng.ready    = ready_r;
  assign done         = done_r;
  assign err          = err_r;
  assign cycles       = cycles_r;
  assign dump_valid   = dump_valid_r;
  assign dump_data    = dump_data_r;

  // Run sequencing and busy-cycle timer; the ARM->RUN edge already counts one busy cycle.
  always_comb begin
    state_s  = state_r;
    cycles_s = cycles_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s  = S_ARM;
          cycles_s = 24'd0;
        end else begin
          state_s  = state_r;
        end
      end
      S_ARM: begin
        if (eng.busy) begin
          state_s  = S_RUN;
          cycles_s = 24'd1;
        end else begin
          state_s  = S_ARM;
        end
      end
      S_RUN: begin
        if (!eng.busy) begin
          state_s = S_DONE;
        end else if (cycles_r != CYC_MAX) begin
          cycles_s = cycles_r + 24'd1;
        end else begin
          cycles_s = cycles_r;
        end
      end
      default: begin
        state_s  = S_IDLE;
        cycles_s = 24'd0;
      end
    endcase
  end

  // Control registers; ready/done are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
      cycles_r <= 24'd0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      ready_r  <= (state_s == S_ARM);
      done_r   <= (state_s == S_DONE);
      cycles_r <= cycles_s;
      err_r    <= err_r | err_set_s;
    end
  end

  // Readback samples memory before this edge's writes land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_valid_r <= 1'b0;
      dump_data_r  <= {DATA_W{1'b0}};
    end else begin
      dump_valid_r <= dump_req;
      if (dump_req) begin
        dump_data_r <= read_bank(dump_sel, dump_addr);
      end
    end
  end

  // Image loader; dropped while the engine is running.
  always_ff @(posedge clk) begin
    if (ld_valid && (state_r != S_RUN)) begin
      img_mem[ld_addr[IMG_AW-1:0]] <= ld_data;
    end
  end

  // Engine layer writes, accepted in any state.
  always_ff @(posedge clk) begin
    if (eng_wr_s) begin
      case (eng.csel)
        SEL_L0K0: l0k0_mem[eng.caddr_wr[L0_AW-1:0]] <= eng.cdata_wr;
        SEL_L0K1: l0k1_mem[eng.caddr_wr[L0_AW-1:0]] <= eng.cdata_wr;
        SEL_L1K0: l1k0_mem[eng.caddr_wr[L1_AW-1:0]] <= eng.cdata_wr;
        SEL_L1K1: l1k1_mem[eng.caddr_wr[L1_AW-1:0]] <= eng.cdata_wr;
        SEL_L2:   l2_mem[eng.caddr_wr[L2_AW-1:0]]   <= eng.cdata_wr;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_mem_host.sv
// Directed and randomized bench for conv_layer_mem_host against a bank-array reference model.
module tb_conv_layer_mem_host;
  logic        clk = 1'b0;
  logic        reset, ld_valid, start, dump_req, dump_valid, done, err;
  logic [11:0] ld_addr, dump_addr;
  logic [19:0] ld_data, dump_data;
  logic [2:0]  dump_sel;
  logic [23:0] cycles;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {int sel; int addr;} loc_t;
  logic [19:0] m_mem [6][4096];
  loc_t        wq[$];

  conv_layer_mem_host_if #(.DATA_W(20), .ADDR_W(12)) bus();

  conv_layer_mem_host dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .eng(bus), .dump_req(dump_req), .dump_sel(dump_sel), .dump_addr(dump_addr),
    .dump_valid(dump_valid), .dump_data(dump_data), .done(done), .err(err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int depth_of(input int sel);
    case (sel)
      0, 1, 2: return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  task automatic ld_write(input int addr, input logic [19:0] d);
    ld_valid = 1'b1; ld_addr = addr[11:0]; ld_data = d;
    tick();
    ld_valid = 1'b0;
    m_mem[0][addr] = d;
    wq.push_back('{0, addr});
  endtask

  task automatic eng_write(input int sel, input int addr, input logic [19:0] d);
    bus.cwr = 1'b1; bus.csel = sel[2:0]; bus.caddr_wr = addr[11:0]; bus.cdata_wr = d;
    tick();
    bus.cwr = 1'b0;
    if (sel >= 1 && sel <= 5 && addr < depth_of(sel)) begin
      m_mem[sel][addr] = d;
      wq.push_back('{sel, addr});
    end
  endtask

  task automatic check_read(input int sel, input int addr);
    logic [19:0] exp_v;
    exp_v = m_mem[sel][addr];
    if (sel == 0) begin
      bus.iaddr = addr[11:0];
      #1 chk("idata", bus.idata, exp_v);
    end else begin
      bus.crd = 1'b1; bus.csel = sel[2:0]; bus.caddr_rd = addr[11:0];
      #1 chk("cdata_rd", bus.cdata_rd, exp_v);
    end
    dump_req = 1'b1; dump_sel = sel[2:0]; dump_addr = addr[11:0];
    tick();
    bus.crd = 1'b0; dump_req = 1'b0;
    chk("dump_valid", dump_valid, 1);
    chk("dump_data", dump_data, exp_v);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1 chk("err_reset", err, 0);
    tick();
    reset = 1'b0;
  endtask

  // One run: busy held low for arm_wait cycles after the start edge, then high for busy_len cycles.
  task automatic do_run(input int arm_wait, input int busy_len);
    int ready_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_clr", done, 0);
    chk("cycles_clr", cycles, 0);
    ready_cnt = 0;
    for (int i = 0; i < arm_wait; i++) begin
      ready_cnt += int'(bus.ready);
      tick();
    end
    bus.busy = 1'b1;
    ready_cnt += int'(bus.ready);
    tick();
    chk("ready_fall", bus.ready, 0);
    chk("ready_len", ready_cnt, arm_wait + 1);
    for (int i = 1; i < busy_len; i++) tick();
    chk("done_early", done, 0);
    bus.busy = 1'b0;
    tick();
    chk("done_set", done, 1);
    chk("cycles", cycles, busy_len);
  endtask

  initial begin
    int sel, addr;
    logic [19:0] d;
    loc_t l;
    reset = 1'b1; ld_valid = 1'b0; ld_addr = 12'd0; ld_data = 20'd0; start = 1'b0;
    dump_req = 1'b0; dump_sel = 3'd0; dump_addr = 12'd0;
    bus.busy = 1'b0; bus.iaddr = 12'd0; bus.cwr = 1'b0; bus.caddr_wr = 12'd0; bus.cdata_wr = 20'd0;
    bus.crd = 1'b0; bus.caddr_rd = 12'd0; bus.csel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_data", dump_data, 0);
    reset = 1'b0;

    // Image loader and zero-latency image reads.
    ld_write(0, 20'h0A89E);
    ld_write(4095, 20'hFFFFF);
    bus.iaddr = 12'd0;
    #1 chk("idata_0", bus.idata, 20'h0A89E);
    bus.iaddr = 12'd4095;
    #1 chk("idata_4095", bus.idata, 20'hFFFFF);
    repeat (8) ld_write($urandom_range(1, 4094), 20'($urandom));

    // L1 bank separation, engine read and readback.
    eng_write(4, 5, 20'h00777);
    eng_write(3, 5, 20'h12345);
    check_read(3, 5);
    check_read(4, 5);
    tick();
    chk("dump_valid_drop", dump_valid, 0);
    bus.csel = 3'b011; bus.caddr_rd = 12'd5; bus.crd = 1'b0;
    #1 chk("cdata_rd_idle", bus.cdata_rd, 0);

    // Boundary addresses and random traffic.
    eng_write(3, 1023, 20'h3FF3F);
    eng_write(5, 2047, 20'h7FF7F);
    eng_write(5, 0, 20'h0BEEF);
    eng_write(1, 4095, 20'hA5A5A);
    check_read(3, 1023);
    check_read(5, 2047);
    repeat (24) begin
      sel = $urandom_range(1, 5);
      addr = $urandom_range(0, depth_of(sel) - 1);
      eng_write(sel, addr, 20'($urandom));
    end
    repeat (20) begin
      l = wq[$urandom_range(0, wq.size() - 1)];
      check_read(l.sel, l.addr);
    end

    // Readback in the same cycle as a write sees the old word.
    eng_write(2, 7, 20'h11111);
    bus.cwr = 1'b1; bus.csel = 3'b010; bus.caddr_wr = 12'd7; bus.cdata_wr = 20'h22222;
    dump_req = 1'b1; dump_sel = 3'b010; dump_addr = 12'd7;
    tick();
    bus.cwr = 1'b0; dump_req = 1'b0;
    chk("dump_old", dump_data, 20'h11111);
    m_mem[2][7] = 20'h22222;
    check_read(2, 7);
    chk("err_clean", err, 0);

    // Runs: directed then random from DONE.
    do_run(3, 100);
    do_run($urandom_range(0, 5), $urandom_range(1, 60));
    chk("err_after_runs", err, 0);

    // Out-of-range and illegal-select accesses.
    eng_write(5, 2048, 20'h54321);
    chk("err_l2_oob", err, 1);
    check_read(5, 0);
    eng_write(6, 3, 20'h00001);
    chk("err_sticky", err, 1);
    reset_pulse();
    bus.crd = 1'b1; bus.csel = 3'b011; bus.caddr_rd = 12'd1024;
    #1 chk("l1_oob_rd", bus.cdata_rd, 0);
    tick();
    bus.crd = 1'b0;
    chk("err_l1_oob", err, 1);
    reset_pulse();
    bus.busy = 1'b1;
    tick();
    bus.busy = 1'b0;
    chk("err_busy_idle", err, 1);
    reset_pulse();

    // Loader during RUN, then reset mid-run.
    start = 1'b1;
    tick();
    start = 1'b0; bus.busy = 1'b1;
    tick();
    ld_valid = 1'b1; ld_addr = 12'd0; ld_data = 20'h55555;
    tick();
    ld_valid = 1'b0;
    chk("err_ld_run", err, 1);
    tick();
    reset = 1'b1; bus.busy = 1'b0;
    #1 chk("midrun_ready", bus.ready, 0);
    chk("midrun_done", done, 0);
    tick();
    reset = 1'b0;
    check_read(0, 0);
    check_read(1, 4095);
    bus.busy = 1'b1;
    tick();
    bus.busy = 1'b0;
    chk("idle_after_reset", err, 1);
    reset_pulse();

    // Reset while armed.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_ready", bus.ready, 1);
    reset = 1'b1;
    #1 chk("arm_reset_ready", bus.ready, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("arm_reset_stays", bus.ready, 0);
    do_run(1, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
